// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I main controller. A state machine sequences each instruction
// from FETCH through writeback and drives the memory, ALU-mux and register-file
// controls of the multicycle datapath. It supports a memory wait-state handshake,
// optional LUI/AUIPC decoding, and a sticky trap on unknown opcodes.
module multicycle_ctrl #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ENABLE_UTYPE  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       Branch,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_EXECU    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_JAL      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t state;
  logic   ready;
  logic   pc_update;

  assign ready     = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state_dbg = state;

  // State sequencing; memory states hold until the access completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (ready) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            7'b0000011, 7'b0100011: state <= S_MEMADR;
            7'b0110011:             state <= S_EXECR;
            7'b0010011:             state <= S_EXECI;
            7'b1100011:             state <= S_BEQ;
            7'b1101111:             state <= S_JAL;
            7'b0110111, 7'b0010111: state <= ENABLE_UTYPE ? S_EXECU : S_TRAP;
            default:                state <= S_TRAP;
          endcase
        end
        S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_EXECU:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BEQ:      state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // State-decoded controls; the ready-gated strobes are also masked by reset
  // because the asynchronous reset parks the machine in FETCH.
  always_comb begin
    pc_update = 1'b0;
    Branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    illegal   = 1'b0;
    ResultSrc = '0;
    ALUSrcA   = '0;
    ALUSrcB   = '0;
    ALUOp     = '0;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = ready & ~reset;
        pc_update = ready & ~reset;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = ready & ~reset;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_EXECU: begin
        ALUSrcA = op[5] ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_TRAP:     illegal = 1'b1;
      default: ;
    endcase
    PCWrite = pc_update | (Branch & Zero);
  end

  // Immediate format follows the opcode directly.
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      7'b0100011:             ImmSrc = 3'b001;
      7'b1100011:             ImmSrc = 3'b010;
      7'b1101111:             ImmSrc = 3'b011;
      7'b0110111, 7'b0010111: ImmSrc = ENABLE_UTYPE ? 3'b100 : 3'b000;
      default:                ImmSrc = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its
// expected list of phases, and every cycle is compared against the control
// word that phase must present.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = '0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, Branch, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic [3:0] state_dbg;

  logic       reset2 = 1'b1;
  logic [6:0] op2 = '0;
  logic       mem_ready2 = 1'b0;
  logic       PCWrite2, Branch2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2, illegal2;
  logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2, ALUOp2;
  logic [2:0] ImmSrc2;
  logic [3:0] state_dbg2;

  int n_tests = 0;
  int n_fail  = 0;
  int last_cycles, last_mw, last_hold;

  logic [17:0] obs;
  assign obs = {PCWrite, Branch, AdrSrc, MemWrite, IRWrite, RegWrite, illegal,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc};

  multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .ENABLE_UTYPE(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .Branch(Branch), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  multicycle_ctrl #(.MEM_HANDSHAKE(1'b0), .ENABLE_UTYPE(1'b0)) dut_min (
    .clk(clk), .reset(reset2), .op(op2), .Zero(1'b0), .mem_ready(mem_ready2),
    .PCWrite(PCWrite2), .Branch(Branch2), .AdrSrc(AdrSrc2), .MemWrite(MemWrite2),
    .IRWrite(IRWrite2), .RegWrite(RegWrite2), .ResultSrc(ResultSrc2),
    .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2), .ImmSrc(ImmSrc2),
    .illegal(illegal2), .state_dbg(state_dbg2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    return o == OP_LW || o == OP_SW || o == OP_R || o == OP_I ||
           o == OP_BEQ || o == OP_JAL || o == OP_LUI || o == OP_AUI;
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o, input bit ut);
    if (o == OP_SW)                      return 3'b001;
    if (o == OP_BEQ)                     return 3'b010;
    if (o == OP_JAL)                     return 3'b011;
    if (ut && (o == OP_LUI || o == OP_AUI)) return 3'b100;
    return 3'b000;
  endfunction

  // Control word each phase must present, straight from the phase table.
  function automatic logic [17:0] exp_ctrl(input int ph, input bit rdy, input bit z,
                                           input logic [6:0] o);
    logic pcw, br, adr, mw, irw, rw, ill;
    logic [1:0] res, sa, sb, aop;
    {pcw, br, adr, mw, irw, rw, ill} = '0;
    {res, sa, sb, aop} = '0;
    case (ph)
      0:  begin sb = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
      1:  begin sa = 2'b01; sb = 2'b01; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  adr = 1'b1;
      4:  begin res = 2'b01; rw = 1'b1; end
      5:  begin adr = 1'b1; mw = rdy; end
      6:  begin sa = 2'b10; aop = 2'b10; end
      7:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      8:  begin sa = o[5] ? 2'b11 : 2'b01; sb = 2'b01; end
      9:  rw = 1'b1;
      10: begin sa = 2'b10; aop = 2'b01; br = 1'b1; pcw = z; end
      11: begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      12: ill = 1'b1;
      default: ;
    endcase
    return {pcw, br, adr, mw, irw, rw, ill, res, sa, sb, aop, imm_of(o, 1'b1)};
  endfunction

  // Holds reset across a rising edge, checks the reset state, and releases
  // just after the edge so the next instruction starts in FETCH.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    op = 7'($urandom);
    #1;
    check("rst_state", state_dbg, 0);
    check("rst_strobes", {PCWrite, Branch, MemWrite, IRWrite, RegWrite, illegal}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // force_rdy: mem_ready high except mem_waits stalls in MEMREAD/MEMWRITE.
  // zmode: 0 random Zero, 1 Zero high, 2 Zero low. Illegal ops sit in TRAP
  // for trap_n cycles and leave the machine trapped.
  task automatic run_instr(input logic [6:0] opc, input bit force_rdy,
                           input int mem_waits, input int zmode, input int trap_n);
    int ph_q[$];
    int ph;
    int waits = 0;
    bit rdy, z, is_mem;
    logic [6:0] o;
    ph_q.push_back(0);
    ph_q.push_back(1);
    case (opc)
      OP_LW:  begin ph_q.push_back(2); ph_q.push_back(3); ph_q.push_back(4); end
      OP_SW:  begin ph_q.push_back(2); ph_q.push_back(5); end
      OP_R:   begin ph_q.push_back(6); ph_q.push_back(9); end
      OP_I:   begin ph_q.push_back(7); ph_q.push_back(9); end
      OP_BEQ: ph_q.push_back(10);
      OP_JAL: begin ph_q.push_back(11); ph_q.push_back(9); end
      OP_LUI, OP_AUI: begin ph_q.push_back(8); ph_q.push_back(9); end
      default: for (int k = 0; k < trap_n; k++) ph_q.push_back(12);
    endcase
    last_cycles = 0;
    last_mw = 0;
    last_hold = 0;
    while (ph_q.size() > 0) begin
      ph = ph_q[0];
      @(negedge clk);
      o = (ph == 1 || ph == 2 || ph == 8) ? opc : 7'($urandom);
      is_mem = (ph == 0 || ph == 3 || ph == 5);
      if (force_rdy) rdy = !((ph == 3 || ph == 5) && waits < mem_waits);
      else           rdy = (waits >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
      case (zmode)
        1:       z = 1'b1;
        2:       z = 1'b0;
        default: z = 1'($urandom);
      endcase
      op = o;
      mem_ready = rdy;
      Zero = z;
      #1;
      check("state", state_dbg, ph);
      check("ctrl", obs, exp_ctrl(ph, rdy, z, o));
      last_cycles++;
      if (ph == 5) last_hold++;
      if (MemWrite) last_mw++;
      if (is_mem && !rdy) waits++;
      else begin
        waits = 0;
        void'(ph_q.pop_front());
      end
    end
  endtask

  initial begin
    logic [6:0] legal_ops [8];
    logic [6:0] o;
    legal_ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_LUI, OP_AUI};

    do_reset();

    run_instr(OP_LW, 1'b1, 0, 0, 0);  check("lat_lw", last_cycles, 5);
    run_instr(OP_SW, 1'b1, 2, 0, 0);
    check("sw_hold", last_hold, 3);
    check("sw_pulses", last_mw, 1);
    check("lat_sw_wait", last_cycles, 6);
    run_instr(OP_SW, 1'b1, 0, 0, 0);  check("lat_sw", last_cycles, 4);
    run_instr(OP_R, 1'b1, 0, 0, 0);   check("lat_r", last_cycles, 4);
    run_instr(OP_I, 1'b1, 0, 0, 0);   check("lat_i", last_cycles, 4);
    run_instr(OP_JAL, 1'b1, 0, 0, 0); check("lat_jal", last_cycles, 4);
    run_instr(OP_LUI, 1'b1, 0, 0, 0); check("lat_lui", last_cycles, 4);
    run_instr(OP_AUI, 1'b1, 0, 0, 0); check("lat_auipc", last_cycles, 4);
    run_instr(OP_BEQ, 1'b1, 0, 1, 0); check("lat_beq", last_cycles, 3);
    run_instr(OP_BEQ, 1'b1, 0, 2, 0);

    run_instr(7'b1111111, 1'b1, 0, 0, 10);
    do_reset();

    // Reset during a stalled store: no MemWrite, straight back to FETCH.
    @(negedge clk);
    op = OP_SW;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("mid_state", state_dbg, 5);
    check("mid_mw", MemWrite, 0);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("mid_rst_state", state_dbg, 0);
    check("mid_rst_strobes", {PCWrite, MemWrite, IRWrite, RegWrite}, 0);
    @(posedge clk);
    #1;
    check("mid_hold_strobes", {MemWrite, RegWrite}, 0);
    reset = 1'b0;
    run_instr(OP_LW, 1'b1, 0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do o = 7'($urandom); while (is_legal(o));
        run_instr(o, 1'b0, 0, 0, $urandom_range(1, 5));
        do_reset();
      end else begin
        run_instr(legal_ops[$urandom_range(0, 7)], 1'b0, 0, 0, 0);
      end
    end

    // Minimal build: handshake ignored, U-type traps.
    @(negedge clk);
    op2 = OP_LUI;
    mem_ready2 = 1'b0;
    @(posedge clk);
    #1 reset2 = 1'b0;
    @(negedge clk);
    #1;
    check("min_fetch_state", state_dbg2, 0);
    check("min_fetch_irw", IRWrite2, 1);
    @(negedge clk);
    #1;
    check("min_decode_state", state_dbg2, 1);
    check("min_lui_imm", ImmSrc2, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_ready2 = 1'($urandom);
      #1;
      check("min_trap_state", state_dbg2, 12);
      check("min_trap_ill", illegal2, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
